nn_mul_acc_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-cycle unsigned multiplier cores.
- Multiplies two operands with per-operand signedness and a configurable pipeline depth.
- Optionally accumulates products over a vector and emits one result per vector.
- Used inside the AlexNet conv/FC datapath as the dot-product element; carries valid/ready flow control and a clock enable.

---
 rtl/nn_mul_acc_pipe.sv | 129 ++++++++++++
 tb/tb_nn_mul_acc_pipe.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mul_acc_pipe.sv
// Pipelined multiplier, per-operand signedness, optional per-vector accumulate; NUM_STAGE cycles latency.
// ce=0 or a held result (out_valid & ~out_ready) freezes every stage; in_ready drops for the duration.
module nn_mul_acc_pipe #(
  parameter int DIN0_WIDTH  = 8,
  parameter int DIN1_WIDTH  = 8,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 3,
  parameter int ACC_EN      = 1,
  parameter int DOUT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);
  localparam int MW  = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam bit ACC = (ACC_EN != 0);

  logic                         w_adv;
  logic                         w_take;
  logic                         w_sx0, w_sx1;
  logic signed [DIN0_WIDTH:0]   w_a;
  logic signed [DIN1_WIDTH:0]   w_b;
  logic signed [MW-1:0]         w_m;
  logic [DOUT_WIDTH-1:0]        w_prod;
  logic [DOUT_WIDTH-1:0]        w_fin_prod;
  logic                         w_fin_vld, w_fin_first, w_fin_last;
  logic [DOUT_WIDTH-1:0]        w_base, w_sum;
  logic                         w_add_ovf, w_ovf_nxt;

  logic                         r_out_valid;
  logic [DOUT_WIDTH-1:0]        r_dout;
  logic                         r_ovf;
  logic [DOUT_WIDTH-1:0]        r_acc;
  logic                         r_ovf_run;

  assign w_adv    = ce & ~(r_out_valid & ~out_ready);
  assign in_ready = w_adv;
  assign w_take   = in_valid & w_adv;

  // Operands widened by one bit so unsigned values stay positive in the signed multiply.
  assign w_sx0  = (DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1];
  assign w_sx1  = (DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1];
  assign w_a    = signed'({w_sx0, din0});
  assign w_b    = signed'({w_sx1, din1});
  assign w_m    = MW'(w_a) * MW'(w_b);
  assign w_prod = DOUT_WIDTH'(w_m);

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign w_fin_prod  = w_prod;
      assign w_fin_vld   = w_take;
      assign w_fin_first = in_first;
      assign w_fin_last  = in_last;
    end else begin : g_pipe
      logic [NUM_STAGE-2:0][DOUT_WIDTH-1:0] r_pd;
      logic [NUM_STAGE-2:0]                 r_pv, r_pf, r_pl;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_pd <= '0;
          r_pv <= '0;
          r_pf <= '0;
          r_pl <= '0;
        end else if (w_adv) begin
          r_pd[0] <= w_prod;
          r_pv[0] <= w_take;
          r_pf[0] <= in_first;
          r_pl[0] <= in_last;
          for (int k = 1; k < NUM_STAGE - 1; k++) begin
            r_pd[k] <= r_pd[k-1];
            r_pv[k] <= r_pv[k-1];
            r_pf[k] <= r_pf[k-1];
            r_pl[k] <= r_pl[k-1];
          end
        end
      end

      assign w_fin_prod  = r_pd[NUM_STAGE-2];
      assign w_fin_vld   = r_pv[NUM_STAGE-2];
      assign w_fin_first = r_pf[NUM_STAGE-2];
      assign w_fin_last  = r_pl[NUM_STAGE-2];
    end
  endgenerate

  // A first beat restarts from zero, which can never overflow, so the sticky flag restarts too.
  assign w_base    = w_fin_first ? '0 : r_acc;
  assign w_sum     = w_base + w_fin_prod;
  assign w_add_ovf = (w_base[DOUT_WIDTH-1] == w_fin_prod[DOUT_WIDTH-1]) &
                     (w_sum[DOUT_WIDTH-1] != w_base[DOUT_WIDTH-1]);
  assign w_ovf_nxt = (w_fin_first ? 1'b0 : r_ovf_run) | w_add_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
      r_ovf_run   <= 1'b0;
    end else if (w_adv) begin
      if (w_fin_vld && ACC) begin
        r_acc     <= w_sum;
        r_ovf_run <= w_ovf_nxt;
      end
      if (w_fin_vld && (!ACC || w_fin_last)) begin
        r_out_valid <= 1'b1;
        r_dout      <= ACC ? w_sum : w_fin_prod;
        r_ovf       <= ACC & w_ovf_nxt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nn_mul_acc_pipe.sv
// Bench for nn_mul_acc_pipe: one accumulating signed instance and two product-only instances.
// Expected results are queued at stimulus time and compared when each DUT presents them.
module tb_nn_mul_acc_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } acc_exp_t;

  // Accumulating instance: signed 8x8, 4 stages, 16-bit result.
  logic        a_reset, a_ce, a_in_valid, a_in_ready, a_first, a_last;
  logic        a_out_valid, a_out_ready, a_ovf;
  logic [7:0]  a_din0, a_din1;
  logic [15:0] a_dout;

  // Product-only instances share one input stream.
  logic        m_reset, m_ce, m_in_valid, m_first, m_last, m_out_ready;
  logic [7:0]  m_din0, m_din1;
  logic        mu_in_ready, mu_out_valid, mu_ovf;
  logic        ms_in_ready, ms_out_valid, ms_ovf;
  logic [23:0] mu_dout, ms_dout;

  acc_exp_t    q_a[$];
  logic [23:0] q_u[$];
  logic [23:0] q_s[$];
  int          m_acc;
  logic        m_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  nn_mul_acc_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DIN0_SIGNED(1), .DIN1_SIGNED(1),
                    .NUM_STAGE(4), .ACC_EN(1), .DOUT_WIDTH(16)) u_acc (
    .clk(clk), .reset(a_reset), .ce(a_ce), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .din0(a_din0), .din1(a_din1), .in_first(a_first), .in_last(a_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout), .ovf(a_ovf));

  nn_mul_acc_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DIN0_SIGNED(0), .DIN1_SIGNED(0),
                    .NUM_STAGE(3), .ACC_EN(0), .DOUT_WIDTH(24)) u_mulu (
    .clk(clk), .reset(m_reset), .ce(m_ce), .in_valid(m_in_valid), .in_ready(mu_in_ready),
    .din0(m_din0), .din1(m_din1), .in_first(m_first), .in_last(m_last),
    .out_valid(mu_out_valid), .out_ready(m_out_ready), .dout(mu_dout), .ovf(mu_ovf));

  nn_mul_acc_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DIN0_SIGNED(1), .DIN1_SIGNED(0),
                    .NUM_STAGE(1), .ACC_EN(0), .DOUT_WIDTH(24)) u_muls (
    .clk(clk), .reset(m_reset), .ce(m_ce), .in_valid(m_in_valid), .in_ready(ms_in_ready),
    .din0(m_din0), .din1(m_din1), .in_first(m_first), .in_last(m_last),
    .out_valid(ms_out_valid), .out_ready(m_out_ready), .dout(ms_dout), .ovf(ms_ovf));

  task automatic run_monitors();
    acc_exp_t    e;
    logic [23:0] ev;
    forever begin
      @(negedge clk);
      if (!a_reset && a_ce && a_out_valid && a_out_ready) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_err++;
          $display("FAIL acc_result: got dout=%0d ovf=%0b, required no result", $signed(a_dout), a_ovf);
        end else begin
          e = q_a.pop_front();
          if (a_dout !== e.d || a_ovf !== e.o) begin
            n_err++;
            $display("FAIL acc_result: got dout=%0d ovf=%0b, required dout=%0d ovf=%0b",
                     $signed(a_dout), a_ovf, $signed(e.d), e.o);
          end
        end
      end
      if (!m_reset && mu_out_valid) begin
        n_cmp++;
        if (q_u.size() == 0) begin
          n_err++;
          $display("FAIL mulu_result: got dout=%0h, required no result", mu_dout);
        end else begin
          ev = q_u.pop_front();
          if (mu_dout !== ev || mu_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL mulu_result: got dout=%0h ovf=%0b, required dout=%0h ovf=0", mu_dout, mu_ovf, ev);
          end
        end
      end
      if (!m_reset && ms_out_valid) begin
        n_cmp++;
        if (q_s.size() == 0) begin
          n_err++;
          $display("FAIL muls_result: got dout=%0h, required no result", ms_dout);
        end else begin
          ev = q_s.pop_front();
          if (ms_dout !== ev || ms_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL muls_result: got dout=%0h ovf=%0b, required dout=%0h ovf=0", ms_dout, ms_ovf, ev);
          end
        end
      end
    end
  endtask

  // Drives one beat into u_acc until accepted; the model updates on acceptance.
  task automatic acc_beat(input logic [7:0] x, input logic [7:0] y, input logic f, input logic l);
    int          s, px, py, n;
    logic [15:0] w16;
    acc_exp_t    e;
    a_in_valid = 1'b1; a_din0 = x; a_din1 = y; a_first = f; a_last = l;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL acc_accept: in_ready=%0b after %0d cycles, required 1", a_in_ready, n);
    end else begin
      px = $signed(x);
      py = $signed(y);
      if (f) begin
        m_acc = 0;
        m_ovf = 1'b0;
      end
      s = m_acc + px * py;
      if (s > 32767 || s < -32768) m_ovf = 1'b1;
      w16 = s[15:0];
      m_acc = $signed(w16);
      if (l) begin
        e.d = w16;
        e.o = m_ovf;
        q_a.push_back(e);
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; m_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0; m_reset = 1'b0;
    m_acc = 0; m_ovf = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_dout !== 16'd0 || a_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_acc: got out_valid=%0b dout=%0h ovf=%0b, required 0 0 0", a_out_valid, a_dout, a_ovf);
    end
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %0b, required 1", a_in_ready);
    end
    n_cmp++;
    if (mu_out_valid !== 1'b0 || mu_dout !== 24'd0 || ms_out_valid !== 1'b0 || ms_dout !== 24'd0) begin
      n_err++;
      $display("FAIL reset_mul: got valids=%0b%0b douts=%0h/%0h, required 0", mu_out_valid, ms_out_valid, mu_dout, ms_dout);
    end
    n_cmp++;
    if (mu_in_ready !== 1'b1 || ms_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mul_ready: got %0b%0b, required 11", mu_in_ready, ms_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [7:0] xt [6] = '{8'hFF, 8'h80, 8'h00, 8'h7F, 8'h01, 8'h80};
    logic [7:0] yt [6] = '{8'hFF, 8'hFF, 8'hAB, 8'h80, 8'h01, 8'h80};
    logic [7:0] x, y;
    int         sx, n_u, n_s;
    // Lone beat measures latency of both instances.
    m_in_valid = 1'b1; m_din0 = 8'hFF; m_din1 = 8'hFF;
    q_u.push_back(24'd65025);
    q_s.push_back(24'hFFFF01);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    n_u = 0; n_s = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mu_out_valid && n_u == 0) n_u = c;
      if (ms_out_valid && n_s == 0) n_s = c;
    end
    n_cmp++;
    if (n_u != 3) begin
      n_err++;
      $display("FAIL mulu_latency: got %0d cycles, required 3", n_u);
    end
    n_cmp++;
    if (n_s != 1) begin
      n_err++;
      $display("FAIL muls_latency: got %0d cycles, required 1", n_s);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        x = xt[i]; y = yt[i];
      end else begin
        x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
      end
      sx = $signed(x);
      q_u.push_back(24'(int'(x) * int'(y)));
      q_s.push_back(24'(sx * int'(y)));
      m_in_valid = 1'b1; m_din0 = x; m_din1 = y;
      m_first = 1'($urandom_range(0, 1)); m_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
    for (int c = 0; c < 20 && (q_u.size() != 0 || q_s.size() != 0); c++) @(posedge clk);
    #1;
    n_cmp++;
    if (q_u.size() != 0 || q_s.size() != 0) begin
      n_err++;
      $display("FAIL mul_drain: pending %0d/%0d, required 0/0", q_u.size(), q_s.size());
    end
  endtask

  task automatic test_dot();
    int n_out;
    acc_beat(8'd3, 8'd4, 1'b1, 1'b0);
    acc_beat(8'd5, 8'd6, 1'b0, 1'b0);
    acc_beat(8'hFE, 8'd7, 1'b0, 1'b0);
    acc_beat(8'd1, 8'd1, 1'b0, 1'b1);
    acc_beat(8'd1, 8'd1, 1'b1, 1'b1);
    n_out = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_out_valid) n_out++;
    end
    n_cmp++;
    if (n_out != 2) begin
      n_err++;
      $display("FAIL dot_count: got %0d results, required 2", n_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL dot_drain: pending %0d, required 0", q_a.size());
    end
  endtask

  task automatic test_overflow();
    acc_beat(8'd127, 8'd127, 1'b1, 1'b0);
    acc_beat(8'd127, 8'd127, 1'b0, 1'b0);
    acc_beat(8'd127, 8'd127, 1'b0, 1'b1);
    acc_beat(8'd1, 8'd2, 1'b1, 1'b1);
    acc_beat(8'h81, 8'h81, 1'b1, 1'b0);
    acc_beat(8'h80, 8'h80, 1'b0, 1'b1);
    for (int c = 0; c < 30 && q_a.size() != 0; c++) @(posedge clk);
    #1;
    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL ovf_drain: pending %0d, required 0", q_a.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    bit          ok;
    bit          bp_done;
    int          n;
    a_out_ready = 1'b0;
    acc_beat(8'd2, 8'd9, 1'b1, 1'b1);
    acc_beat(8'd3, 8'd3, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_out_valid && n < 20);
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: got out_valid=%0b in_ready=%0b, required 1 0", a_out_valid, a_in_ready);
    end
    held = a_dout;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (a_dout !== held || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok || held !== 16'd18) begin
      n_err++;
      $display("FAIL bp_hold: got dout=%0d stable=%0b, required 18 stable=1", held, ok);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          acc_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   (i == 0) || ($urandom_range(0, 3) == 0), (i == 99) || ($urandom_range(0, 2) == 0));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 40 && q_a.size() != 0; c++) @(posedge clk);
    #1;
    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: pending %0d, required 0", q_a.size());
    end
  endtask

  task automatic test_ce_reset();
    logic [15:0] held;
    bit          ok;
    int          n;
    acc_beat(8'd4, 8'd4, 1'b1, 1'b1);
    a_ce = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL ce_freeze: in_ready/out_valid moved while ce=0, required 0/0");
    end
    @(posedge clk); #1;
    a_ce = 1'b1;
    a_out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ce_delay: got out_valid=%0b right after ce returned, required 0", a_out_valid);
    end
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    a_ce = 1'b0;
    a_out_ready = 1'b1;
    held = a_dout;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_dout !== held || a_in_ready !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok || held !== 16'd16) begin
      n_err++;
      $display("FAIL ce_hold: got dout=%0d stable=%0b, required 16 stable=1", held, ok);
    end
    @(posedge clk); #1;
    a_ce = 1'b1;
    acc_beat(8'd5, 8'd5, 1'b1, 1'b0);
    acc_beat(8'd6, 8'd6, 1'b0, 1'b0);
    a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
    m_acc = 0; m_ovf = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_dout !== 16'd0 || a_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL midreset: got out_valid=%0b dout=%0h ovf=%0b, required 0 0 0", a_out_valid, a_dout, a_ovf);
    end
    @(posedge clk); #1;
    acc_beat(8'd2, 8'd3, 1'b0, 1'b1);
    acc_beat(8'd2, 8'd3, 1'b1, 1'b1);
    for (int c = 0; c < 30 && q_a.size() != 0; c++) @(posedge clk);
    #1;
    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL midreset_drain: pending %0d, required 0", q_a.size());
    end
  endtask

  initial begin
    a_reset = 1'b1; a_ce = 1'b1; a_in_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
    a_din0 = '0; a_din1 = '0; a_out_ready = 1'b1;
    m_reset = 1'b1; m_ce = 1'b1; m_in_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
    m_din0 = '0; m_din1 = '0; m_out_ready = 1'b1;
    m_acc = 0; m_ovf = 1'b0;
    fork
      run_monitors();
    join_none
    test_reset();
    test_mul();
    test_dot();
    test_overflow();
    test_backpressure();
    test_ce_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
